branch_predictor: RTL and testbench
===================================

# branch_predictor

Fetch-side branch predictor: a direct-mapped branch target buffer (BTB) with one 2-bit saturating counter per entry. It supplies the taken/target prediction that travels down the pipeline as EX_BP_taken / EX_BP_target_pc, and it is trained by the EX stage's branch resolution. It sits in IF, reads with IF_pc every cycle, and is written from EX results one pipeline span later.

## Interface
- PC_BITS, 12, width of PC and target
- BTB_IDX_BITS, 4, log2 of entry count (16 entries); must be < PC_BITS
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- IF_pc  in  PC_BITS  PC being fetched
- IF_BP_taken  out  1  predicted taken
- IF_BP_target_pc  out  PC_BITS  predicted next PC
- EX_brn  in  1  EX holds a valid branch/jump (0 for bubbles)
- EX_pc  in  PC_BITS  PC of the EX branch
- EX_true_taken  in  1  resolved direction
- EX_alu_out  in  PC_BITS  resolved next PC (low PC_BITS of the ALU result)
- EX_taken  in  1  mispredict/flush indication (used only by stats)
- BP_br_count  out  32  resolved branches (BP_STATS_EN only)
- BP_mispredict_count  out  32  mispredicts (BP_STATS_EN only)

## Operation
- Index = pc[BTB_IDX_BITS-1:0]; tag = pc[PC_BITS-1:BTB_IDX_BITS]. Each entry holds valid, tag, target[PC_BITS], ctr[2].
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Predict (combinational):
  - hit = valid & tag match.
  - IF_BP_taken = hit & ctr[1].
  - IF_BP_target_pc = taken ? entry target : IF_pc+1, modulo 2^PC_BITS (0xFFF -> 0x000).
  - The not-taken target must equal PC+1, because EX compares target against its own resolved next PC even on not-taken.
- Update (clock edge, when EX_brn=1 and rst=0):
  - taken & hit: target <= EX_alu_out; ctr saturating increment.
  - taken & miss (invalid or tag differs): allocate/replace the entry with valid=1, new tag, target=EX_alu_out, ctr=10.
  - not-taken & hit: ctr saturating decrement; valid, tag and target unchanged.
  - not-taken & miss: no write.
- Unconditional jumps resolve as taken and are trained identically.
- No bypass: a same-cycle read of the entry being written returns the pre-update contents.

## Timing
- Prediction latency is 0 cycles (IF_pc to outputs is combinational). An update becomes visible to predictions in the cycle after its edge.
- One update per cycle at most; the predictor never stalls or back-pressures.
- Reset values: all valid=0, all ctr=01, all tag/target=0. Outputs after reset are IF_BP_taken=0 and IF_BP_target_pc=IF_pc+1. Stats counters are 0.
- rst in the same cycle as EX_brn: reset wins and the update is dropped. Reset mid-stream discards all learned state.
- Aliasing: distinct PCs sharing an index evict each other only on a taken update.

## Configuration
- BP_STATS_EN defined:
  - BP_br_count increments on every cycle with EX_brn=1.
  - BP_mispredict_count increments when EX_brn=1 and EX_taken=1.
  - Both saturate at 32'hFFFF_FFFF and clear on rst.
- BP_STATS_EN undefined: both ports and their counters are absent. Prediction and update behaviour are identical in both builds.

## Structure
- Shared package bp_pkg holds:
  - counter encoding localparams (CTR_SNT, CTR_WNT, CTR_WT, CTR_ST);
  - CTR_ALLOC = CTR_WT;
  - the BTB entry typedef (valid, tag, target, ctr).
- One sub-module, bp_sat_ctr: pure 2-bit saturating inc/dec (in: ctr, dir; out: next ctr). It is reused by any future predictor variant.
- Table storage: flop arrays, not SRAM, so that reset clears the table in a single cycle.

## Test plan
- Reset, then IF_pc=0x010 -> taken=0, target=0x011. Then IF_pc=0xFFF -> target=0x000.
- Update EX_pc=0x020, true_taken=1, alu_out=0x080. Next cycle IF_pc=0x020 -> taken=1, target=0x080, ctr=10. Two more taken updates -> ctr=11 and stays 11.
- From ctr=10 on 0x020, apply two not-taken updates -> ctr 01 then 00. IF_pc=0x020 -> taken=0, target=0x021; entry still valid.
- Alias: with 0x020 trained taken, IF_pc=0x030 -> miss, taken=0. A not-taken update at 0x030 leaves 0x020 intact. A taken update at 0x030 (alu_out=0x100) replaces the entry: 0x030 -> taken, 0x100; 0x020 -> miss.
- Same-cycle: IF_pc=0x040 while EX updates 0x040 taken (alu_out=0x050) -> that cycle taken=0, target=0x041. Next cycle taken=1, target=0x050.
- rst=1 together with EX_brn=1, EX_taken=1 -> no entry written. With BP_STATS_EN, both counters read 0. Three branches, one with EX_taken=1 -> br=3, mispredict=1.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg: definitions shared by the branch predictor blocks.
//   - 2-bit direction counter encoding and the value given to a new entry
//   - default PC / index widths
//   - the BTB entry record (valid, tag, target, ctr)
// The entry record is sized by BP_PC_BITS / BP_IDX_BITS. The top-level
// parameters default to these values and must match them.
// ---------------------------------------------------------------------------
package bp_pkg;

    // Direction counter encoding: bit 1 is the taken prediction.
    localparam logic [1:0] CTR_SNT   = 2'b00;  // strong not-taken
    localparam logic [1:0] CTR_WNT   = 2'b01;  // weak not-taken
    localparam logic [1:0] CTR_WT    = 2'b10;  // weak taken
    localparam logic [1:0] CTR_ST    = 2'b11;  // strong taken
    localparam logic [1:0] CTR_ALLOC = CTR_WT; // value given to a new entry

    localparam int BP_PC_BITS  = 12;
    localparam int BP_IDX_BITS = 4;
    localparam int BP_TAG_BITS = BP_PC_BITS - BP_IDX_BITS;

    typedef struct packed {
        logic                   valid;
        logic [BP_TAG_BITS-1:0] tag;
        logic [BP_PC_BITS-1:0]  target;
        logic [1:0]             ctr;
    } bp_entry_t;

endpackage : bp_pkg

// File: rtl/branch_predictor_sat_ctr.sv
// ---------------------------------------------------------------------------
// bp_sat_ctr: pure combinational 2-bit saturating counter step.
//   ctr_i  [1:0]  current counter value
//   dir_i         1 = count up (toward strong-taken), 0 = count down
//   ctr_o  [1:0]  next counter value, saturating at strong-NT and strong-T
// ---------------------------------------------------------------------------
module bp_sat_ctr
    import bp_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       dir_i,
    output logic [1:0] ctr_o
);

    // Saturating increment/decrement over the four counter states.
    always_comb begin
        ctr_o = ctr_i;
        case (ctr_i)
            CTR_SNT: ctr_o = dir_i ? CTR_WNT : CTR_SNT;
            CTR_WNT: ctr_o = dir_i ? CTR_WT  : CTR_SNT;
            CTR_WT:  ctr_o = dir_i ? CTR_ST  : CTR_WNT;
            CTR_ST:  ctr_o = dir_i ? CTR_ST  : CTR_WT;
            default: ctr_o = CTR_WNT;
        endcase
    end

endmodule : bp_sat_ctr

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor: direct-mapped BTB with a 2-bit counter per entry.
// The IF stage reads it with IF_pc (combinational, zero latency). EX branch
// resolutions train it on the clock edge. Same-cycle reads of an entry that
// is being written see the old contents.
//
// Ports
//   clk, rst             clock; synchronous active-high reset
//   IF_pc                fetch PC
//   IF_BP_taken          predicted taken
//   IF_BP_target_pc      predicted next PC (IF_pc+1 when not taken)
//   EX_brn               EX holds a valid branch/jump
//   EX_pc                PC of the EX branch
//   EX_true_taken        resolved direction
//   EX_alu_out           resolved next PC
//   EX_taken             mispredict/flush indication (statistics only)
//   BP_br_count          resolved branch count           (BP_STATS_EN)
//   BP_mispredict_count  mispredict count                (BP_STATS_EN)
//
// Build option: define BP_STATS_EN to add the two saturating statistics
// counters and their ports.
// ---------------------------------------------------------------------------
module branch_predictor
    import bp_pkg::*;
#(
    parameter int PC_BITS      = BP_PC_BITS,
    parameter int BTB_IDX_BITS = BP_IDX_BITS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PC_BITS-1:0] IF_pc,
    output logic               IF_BP_taken,
    output logic [PC_BITS-1:0] IF_BP_target_pc,
    input  logic               EX_brn,
    input  logic [PC_BITS-1:0] EX_pc,
    input  logic               EX_true_taken,
    input  logic [PC_BITS-1:0] EX_alu_out,
`ifdef BP_STATS_EN
    input  logic               EX_taken,
    output logic [31:0]        BP_br_count,
    output logic [31:0]        BP_mispredict_count
`else
    input  logic               EX_taken
`endif
);

    localparam int NUM_ENTRIES = 1 << BTB_IDX_BITS;
    localparam int TAG_BITS    = PC_BITS - BTB_IDX_BITS;

    localparam bp_entry_t ENTRY_RST = '{
        valid:  1'b0,
        tag:    {TAG_BITS{1'b0}},
        target: {PC_BITS{1'b0}},
        ctr:    CTR_WNT
    };

    bp_entry_t btb_q [NUM_ENTRIES];
    bp_entry_t btb_d [NUM_ENTRIES];

    // ---------------- prediction ----------------
    logic [BTB_IDX_BITS-1:0] if_idx_s;
    logic [TAG_BITS-1:0]     if_tag_s;
    bp_entry_t               if_entry_s;
    logic                    if_hit_s;

    assign if_idx_s   = IF_pc[BTB_IDX_BITS-1:0];
    assign if_tag_s   = IF_pc[PC_BITS-1:BTB_IDX_BITS];
    assign if_entry_s = btb_q[if_idx_s];
    assign if_hit_s   = if_entry_s.valid && (if_entry_s.tag == if_tag_s);

    // Not-taken target is PC+1 (wrapping) so EX can compare it against its
    // own resolved next PC on every branch.
    always_comb begin
        if (if_hit_s && if_entry_s.ctr[1]) begin
            IF_BP_taken     = 1'b1;
            IF_BP_target_pc = if_entry_s.target;
        end else begin
            IF_BP_taken     = 1'b0;
            IF_BP_target_pc = IF_pc + PC_BITS'(1);
        end
    end

    // ---------------- training ----------------
    logic [BTB_IDX_BITS-1:0] ex_idx_s;
    logic [TAG_BITS-1:0]     ex_tag_s;
    bp_entry_t               ex_entry_s;
    logic                    ex_hit_s;
    logic [1:0]              ex_ctr_next_s;

    assign ex_idx_s   = EX_pc[BTB_IDX_BITS-1:0];
    assign ex_tag_s   = EX_pc[PC_BITS-1:BTB_IDX_BITS];
    assign ex_entry_s = btb_q[ex_idx_s];
    assign ex_hit_s   = ex_entry_s.valid && (ex_entry_s.tag == ex_tag_s);

    bp_sat_ctr u_sat_ctr (
        .ctr_i (ex_entry_s.ctr),
        .dir_i (EX_true_taken),
        .ctr_o (ex_ctr_next_s)
    );

    // Next table contents: at most one entry changes per cycle. A not-taken
    // miss writes nothing, so aliases only evict each other when taken.
    always_comb begin
        btb_d = btb_q;
        if (EX_brn) begin
            if (EX_true_taken && ex_hit_s) begin
                btb_d[ex_idx_s].target = EX_alu_out;
                btb_d[ex_idx_s].ctr    = ex_ctr_next_s;
            end else if (EX_true_taken) begin
                btb_d[ex_idx_s] = '{
                    valid:  1'b1,
                    tag:    ex_tag_s,
                    target: EX_alu_out,
                    ctr:    CTR_ALLOC
                };
            end else if (ex_hit_s) begin
                btb_d[ex_idx_s].ctr = ex_ctr_next_s;
            end else begin
                btb_d = btb_q;
            end
        end else begin
            btb_d = btb_q;
        end
    end

    // Table state; flops so reset clears every entry in one cycle and
    // overrides any update in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                btb_q[i] <= ENTRY_RST;
            end
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                btb_q[i] <= btb_d[i];
            end
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] br_cnt_q, br_cnt_d;
    logic [31:0] mis_cnt_q, mis_cnt_d;

    // Saturating statistics counters.
    always_comb begin
        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (EX_brn && (br_cnt_q != 32'hFFFF_FFFF)) begin
            br_cnt_d = br_cnt_q + 32'd1;
        end else begin
            br_cnt_d = br_cnt_q;
        end
        if (EX_brn && EX_taken && (mis_cnt_q != 32'hFFFF_FFFF)) begin
            mis_cnt_d = mis_cnt_q + 32'd1;
        end else begin
            mis_cnt_d = mis_cnt_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt_q  <= 32'd0;
            mis_cnt_q <= 32'd0;
        end else begin
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    assign BP_br_count         = br_cnt_q;
    assign BP_mispredict_count = mis_cnt_q;
`else
    // EX_taken only feeds the statistics counters.
    logic unused_ex_taken_s;
    assign unused_ex_taken_s = EX_taken;
`endif

endmodule : branch_predictor

// File: tb/tb_branch_predictor.sv
// ---------------------------------------------------------------------------
// Testbench for branch_predictor. The driver applies one cycle of stimulus
// per negedge and queues the expected prediction from a reference model of
// the BTB. A separate monitor pops and compares shortly after each negedge.
// ---------------------------------------------------------------------------
module tb_branch_predictor;

    localparam int PCB  = 12;
    localparam int NENT = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [PCB-1:0]  IF_pc;
    logic            IF_BP_taken;
    logic [PCB-1:0]  IF_BP_target_pc;
    logic            EX_brn;
    logic [PCB-1:0]  EX_pc;
    logic            EX_true_taken;
    logic [PCB-1:0]  EX_alu_out;
    logic            EX_taken;
    logic [31:0]     BP_br_count;
    logic [31:0]     BP_mispredict_count;

    branch_predictor dut (
        .clk                 (clk),
        .rst                 (rst),
        .IF_pc               (IF_pc),
        .IF_BP_taken         (IF_BP_taken),
        .IF_BP_target_pc     (IF_BP_target_pc),
        .EX_brn              (EX_brn),
        .EX_pc               (EX_pc),
        .EX_true_taken       (EX_true_taken),
        .EX_alu_out          (EX_alu_out),
`ifdef BP_STATS_EN
        .EX_taken            (EX_taken),
        .BP_br_count         (BP_br_count),
        .BP_mispredict_count (BP_mispredict_count)
`else
        .EX_taken            (EX_taken)
`endif
    );

`ifndef BP_STATS_EN
    assign BP_br_count         = 32'd0;
    assign BP_mispredict_count = 32'd0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        bit       taken;
        int       target;
        longint   br;
        longint   mis;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    // Reference model: plain integer arrays, index = pc % 16, tag = pc / 16.
    bit     m_valid [NENT];
    int     m_tag   [NENT];
    int     m_tgt   [NENT];
    int     m_ctr   [NENT];   // 0..3, taken when >= 2
    longint m_br;
    longint m_mis;

    function automatic void model_reset();
        for (int i = 0; i < NENT; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
            m_tgt[i]   = 0;
            m_ctr[i]   = 1;
        end
        m_br  = 0;
        m_mis = 0;
    endfunction

    function automatic exp_t model_predict(input int pc);
        exp_t e;
        int   i;
        bit   hit;
        i   = pc % NENT;
        hit = m_valid[i] && (m_tag[i] == pc / NENT);
        e.taken  = hit && (m_ctr[i] >= 2);
        e.target = e.taken ? m_tgt[i] : (pc + 1) % 4096;
        e.br     = m_br;
        e.mis    = m_mis;
        return e;
    endfunction

    function automatic void model_train(input int pc, input bit tt, input int alu, input bit ext);
        int i;
        bit hit;
        i   = pc % NENT;
        hit = m_valid[i] && (m_tag[i] == pc / NENT);
        if (tt) begin
            if (hit) begin
                m_tgt[i] = alu;
                m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
            end else begin
                m_valid[i] = 1'b1;
                m_tag[i]   = pc / NENT;
                m_tgt[i]   = alu;
                m_ctr[i]   = 2;
            end
        end else if (hit) begin
            m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
        end
        if (m_br  < 64'hFFFF_FFFF) m_br  = m_br + 1;
        if (ext && m_mis < 64'hFFFF_FFFF) m_mis = m_mis + 1;
    endfunction

    // One stimulus cycle: drive, queue the pre-edge expectation, then advance
    // the model to what the table should hold after the edge.
    task automatic step(input bit r, input int ifpc, input bit brn, input int expc,
                        input bit tt, input int alu, input bit ext);
        exp_t e;
        @(negedge clk);
        rst           = r;
        IF_pc         = ifpc[PCB-1:0];
        EX_brn        = brn;
        EX_pc         = expc[PCB-1:0];
        EX_true_taken = tt;
        EX_alu_out    = alu[PCB-1:0];
        EX_taken      = ext;
        e = model_predict(ifpc);
        exp_q.push_back(e);
        mon_en = 1'b1;
        if (r) model_reset();
        else if (brn) model_train(expc, tt, alu, ext);
    endtask

    task automatic look(input int ifpc);
        step(1'b0, ifpc, 1'b0, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic train(input int ifpc, input int expc, input bit tt, input int alu, input bit ext);
        step(1'b0, ifpc, 1'b1, expc, tt, alu, ext);
    endtask

    // Monitor: compares DUT outputs to the queued expectation every cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_empty at pc=%h", IF_pc);
                end else begin
                    e = exp_q.pop_front();
                    checks++;
                    if (IF_BP_taken !== e.taken) begin
                        errors++;
                        $display("FAIL taken pc=%h got %b exp %b", IF_pc, IF_BP_taken, e.taken);
                    end
                    checks++;
                    if (IF_BP_target_pc !== e.target[PCB-1:0]) begin
                        errors++;
                        $display("FAIL target pc=%h got %h exp %h", IF_pc, IF_BP_target_pc, e.target[PCB-1:0]);
                    end
`ifdef BP_STATS_EN
                    checks++;
                    if (BP_br_count !== e.br[31:0]) begin
                        errors++;
                        $display("FAIL br_count got %0d exp %0d", BP_br_count, e.br);
                    end
                    checks++;
                    if (BP_mispredict_count !== e.mis[31:0]) begin
                        errors++;
                        $display("FAIL mispredict_count got %0d exp %0d", BP_mispredict_count, e.mis);
                    end
`endif
                end
            end
        end
    end

    initial begin
        int pc_a, pc_b;
        rst = 1'b1; IF_pc = '0; EX_brn = 1'b0; EX_pc = '0;
        EX_true_taken = 1'b0; EX_alu_out = '0; EX_taken = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);

        // Reset state and PC+1 wrap.
        look(12'h010);
        look(12'hFFF);

        // Train 0x020 taken, then saturate.
        train(12'h020, 12'h020, 1'b1, 12'h080, 1'b0);
        look(12'h020);
        train(12'h020, 12'h020, 1'b1, 12'h080, 1'b0);
        train(12'h020, 12'h020, 1'b1, 12'h080, 1'b0);
        // From 11: NT -> 10 still taken, NT -> 01 not taken.
        train(12'h020, 12'h020, 1'b0, 12'h021, 1'b1);
        look(12'h020);
        train(12'h020, 12'h020, 1'b0, 12'h021, 1'b1);
        look(12'h020);
        train(12'h020, 12'h020, 1'b0, 12'h021, 1'b0);
        look(12'h020);
        // Entry still valid at 00: two taken updates bring it back to taken.
        train(12'h020, 12'h020, 1'b1, 12'h0A0, 1'b1);
        look(12'h020);
        train(12'h020, 12'h020, 1'b1, 12'h0A0, 1'b1);
        look(12'h020);

        // Aliasing between 0x020 and 0x030.
        look(12'h030);
        train(12'h020, 12'h030, 1'b0, 12'h031, 1'b0);
        look(12'h020);
        train(12'h030, 12'h030, 1'b1, 12'h100, 1'b1);
        look(12'h030);
        look(12'h020);

        // Same-cycle read of the entry being written sees old contents.
        train(12'h040, 12'h040, 1'b1, 12'h050, 1'b0);
        look(12'h040);

        // Reset together with a taken branch: nothing written, stats cleared.
        step(1'b1, 12'h060, 1'b1, 12'h060, 1'b1, 12'h070, 1'b1);
        look(12'h060);
        look(12'h030);
        train(12'h000, 12'h001, 1'b0, 12'h002, 1'b0);
        train(12'h000, 12'h002, 1'b1, 12'h009, 1'b1);
        train(12'h000, 12'h003, 1'b0, 12'h004, 1'b0);
        look(12'h002);

        // Randomized traffic over a small PC pool so hits and aliases are common.
        for (int n = 0; n < 1500; n++) begin
            pc_a = ($urandom_range(0, 3) << 4) | $urandom_range(0, 15);
            pc_b = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 4095)
                                               : (($urandom_range(0, 3) << 4) | $urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) pc_b = pc_a;
            step(($urandom_range(0, 99) == 0), pc_b, $urandom_range(0, 2) != 0, pc_a,
                 $urandom_range(0, 1), $urandom_range(0, 4095), $urandom_range(0, 3) == 0);
        end
        look(12'hFFF);

        @(negedge clk);
        mon_en = 1'b0;
        EX_brn = 1'b0;
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_branch_predictor
